// File: rtl/hack_pkg.sv
// Shared types and constants for the Hack boot loader and its helpers.
package hack_pkg;

   typedef enum logic [2:0] {
      RUN,
      LEN_HI,
      LEN_LO,
      DATA_HI,
      DATA_LO,
      CSUM_HI,
      CSUM_LO,
      ERROR
   } loader_state_t;

   // Multi-byte frame fields (LEN, DATA, CSUM) arrive most significant byte first.
   localparam bit BIG_ENDIAN = 1'b1;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 10_000_000;

   function automatic logic [15:0] join_be(input logic [7:0] first, input logic [7:0] second);
      return BIG_ENDIAN ? {first, second} : {second, first};
   endfunction

endpackage

// File: rtl/byte_timeout_counter.sv
// Idle-cycle watchdog for byte streams: counts enabled cycles since the last clear.
module byte_timeout_counter #(
   parameter int unsigned LIMIT = 100
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int unsigned W = $clog2(LIMIT + 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && (count != W'(LIMIT))) begin
         count <= count + 1'b1;
      end
   end

   // Flags the cycle whose closing edge makes the count reach LIMIT, so the consumer
   // reacts on exactly that edge; a clear in the same cycle takes priority.
   assign expired = enable && !clear && (count == W'(LIMIT - 1));

endmodule

// File: rtl/hack_rom_loader.sv
// Boot-time loader: receives a framed program over UART, writes instruction RAM, gates CPU reset.
module hack_rom_loader
   import hack_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_req,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_waddr,
   output logic [15:0]           mem_wdata,
   output logic                  cpu_rst,
   output logic                  loading,
   output logic                  load_error,
   output logic [ADDR_WIDTH:0]   words_loaded
);
   localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
   localparam int unsigned NW    = ADDR_WIDTH + 1;

   loader_state_t         state, state_nx;
   logic [7:0]            hi_q, hi_nx;
   logic [ADDR_WIDTH:0]   n_q, n_nx;
   logic [15:0]           csum_q, csum_nx;
   logic [15:0]           word;
   logic                  mem_we_nx, cpu_rst_nx, loading_nx, load_error_nx;
   logic [ADDR_WIDTH-1:0] mem_waddr_nx;
   logic [15:0]           mem_wdata_nx;
   logic [ADDR_WIDTH:0]   words_nx;
   logic                  go_error, in_frame, tmo_clear, tmo_expired;

   assign word      = join_be(hi_q, rx_data);
   assign in_frame  = !(state inside {RUN, ERROR});
   assign tmo_clear = in_frame ? rx_valid : load_req;

   byte_timeout_counter #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmo_clear),
      .enable  (in_frame),
      .expired (tmo_expired)
   );

   always_comb begin
      state_nx      = state;
      hi_nx         = hi_q;
      n_nx          = n_q;
      csum_nx       = csum_q;
      mem_we_nx     = 1'b0;
      mem_waddr_nx  = mem_waddr;
      mem_wdata_nx  = mem_wdata;
      cpu_rst_nx    = cpu_rst;
      loading_nx    = loading;
      load_error_nx = load_error;
      words_nx      = words_loaded;
      go_error      = 1'b0;

      unique case (state)
         RUN, ERROR: begin
            cpu_rst_nx = (state == ERROR);
            // A byte arriving together with load_req is deliberately dropped.
            if (load_req) begin
               state_nx      = LEN_HI;
               cpu_rst_nx    = 1'b1;
               loading_nx    = 1'b1;
               load_error_nx = 1'b0;
               words_nx      = '0;
               csum_nx       = '0;
            end
         end
         LEN_HI: if (rx_valid) begin
            hi_nx    = rx_data;
            state_nx = LEN_LO;
         end
         LEN_LO: if (rx_valid) begin
            if ((word == 16'd0) || (32'(word) > DEPTH)) begin
               go_error = 1'b1;
            end else begin
               n_nx     = NW'(word);
               state_nx = DATA_HI;
            end
         end
         DATA_HI: if (rx_valid) begin
            hi_nx    = rx_data;
            state_nx = DATA_LO;
         end
         DATA_LO: if (rx_valid) begin
            mem_we_nx    = 1'b1;
            mem_waddr_nx = words_loaded[ADDR_WIDTH-1:0];
            mem_wdata_nx = word;
            words_nx     = words_loaded + 1'b1;
            csum_nx      = csum_q + word;
            state_nx     = (words_nx == n_q) ? CSUM_HI : DATA_HI;
         end
         CSUM_HI: if (rx_valid) begin
            hi_nx    = rx_data;
            state_nx = CSUM_LO;
         end
         CSUM_LO: if (rx_valid) begin
            // cpu_rst stays high here and drops one edge later, after any write has retired.
            if (word == csum_q) begin
               state_nx   = RUN;
               loading_nx = 1'b0;
            end else begin
               go_error = 1'b1;
            end
         end
         default: go_error = 1'b1;
      endcase

      if (tmo_expired) go_error = 1'b1;

      if (go_error) begin
         state_nx      = ERROR;
         cpu_rst_nx    = 1'b1;
         loading_nx    = 1'b0;
         load_error_nx = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= RUN;
         mem_we       <= 1'b0;
         mem_waddr    <= '0;
         mem_wdata    <= '0;
         cpu_rst      <= 1'b1;
         loading      <= 1'b0;
         load_error   <= 1'b0;
         words_loaded <= '0;
      end else begin
         state        <= state_nx;
         mem_we       <= mem_we_nx;
         mem_waddr    <= mem_waddr_nx;
         mem_wdata    <= mem_wdata_nx;
         cpu_rst      <= cpu_rst_nx;
         loading      <= loading_nx;
         load_error   <= load_error_nx;
         words_loaded <= words_nx;
      end
   end

   always_ff @(posedge clk) begin
      hi_q   <= hi_nx;
      n_q    <= n_nx;
      csum_q <= csum_nx;
   end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Boot-time programmer for the Hack instruction memory.
- Receives a framed program image as a byte stream from the UART receiver and writes it word-by-word into the 4K-word distributed instruction RAM.
- Holds the CPU in reset while loading, then releases it.
- Sits between uart_rx, the instruction memory write port and the Hack CPU reset input.

Parameters:
- ADDR_WIDTH, 12, instruction memory address width; depth = 2**ADDR_WIDTH words.
- TIMEOUT_CYCLES, 10_000_000, maximum idle cycles between bytes while loading before abort.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- load_req  input  1  single-cycle pulse (debounced button) requesting a new load.
- rx_data  input  8  received byte.
- rx_valid  input  1  rx_data valid for exactly one cycle.
- mem_we  output  1  instruction memory write enable.
- mem_waddr  output  ADDR_WIDTH  write address.
- mem_wdata  output  16  write data.
- cpu_rst  output  1  active-high reset to the Hack CPU.
- loading  output  1  high while a frame is being received.
- load_error  output  1  sticky error flag.
- words_loaded  output  ADDR_WIDTH+1  words written in the current or last load.

Behaviour:
- Frame format, all fields big-endian (high byte first):
  - LEN: 2 bytes, word count N.
  - DATA: N×2 bytes.
  - CSUM: 2 bytes, sum of all N words mod 2^16.
- All outputs are registered.
- Reset values: mem_we=0, mem_waddr=0, mem_wdata=0, cpu_rst=1, loading=0, load_error=0, words_loaded=0, state=RUN.
- States: RUN, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CSUM_HI, CSUM_LO, ERROR.
- RUN:
  - cpu_rst=0 from the first cycle after rst deasserts; the CPU executes the preloaded image.
  - rx_valid is ignored.
  - load_req → LEN_HI: cpu_rst=1, loading=1, load_error=0, words_loaded=0, address=0, checksum=0.
- LEN_HI/LEN_LO: assemble N.
  - At LEN_LO accept, N==0 or N>2**ADDR_WIDTH → ERROR; otherwise → DATA_HI.
- DATA_HI: latch high byte → DATA_LO.
- DATA_LO, on accept at edge k:
  - During cycle k+1: mem_we=1, mem_wdata={hi,lo}, mem_waddr=current address.
  - At edge k: words_loaded increments and the checksum accumulates (16-bit wrap).
  - After the write, the address increments.
  - If words_loaded reaches N → CSUM_HI; else → DATA_HI.
- CSUM_HI/CSUM_LO: on CSUM_LO accept, match → RUN, mismatch → ERROR.
- Transition to RUN: loading=0 at the next edge; cpu_rst deasserts one cycle later, so the CPU never sees a write in flight.
- ERROR: cpu_rst=1, load_error=1, loading=0. load_req → LEN_HI. Memory contents are undefined (partial image).
- Timeout: the idle counter resets on every accepted byte and on entry to LEN_HI. Counter reaching TIMEOUT_CYCLES in any loading state → ERROR.
- load_req in any loading state is ignored.
- load_req and rx_valid in the same cycle in RUN/ERROR: load_req wins and the byte is dropped.
- mem_we is never high for more than one consecutive cycle per word; never high outside DATA_LO acceptance.
- rst mid-load: immediate return to reset values, then RUN. The partial image stays in memory; no recovery is attempted.

Decomposition:
- hack_pkg:
  - loader_state_t enum.
  - LEN/CSUM byte-order constants.
  - Default TIMEOUT_CYCLES.
- Sub-module byte_timeout_counter (clear, enable, expired), reusable by other UART consumers.
- Everything else lives in one FSM module.

Test Plan:
- After rst, no stimulus → cpu_rst=1 during rst, 0 from the cycle after release; mem_we never asserted.
- load_req, then bytes 00 02 | 12 34 | AB CD | BE 01 → writes (0,0x1234), (1,0xABCD); words_loaded=2; loading falls, cpu_rst falls one cycle later; load_error=0.
- Same frame with checksum BE 02 → both writes occur, then ERROR: load_error=1, cpu_rst stays 1. A subsequent valid load clears load_error.
- LEN 00 00, and separately LEN 10 01 (4097) → ERROR immediately after the second length byte; no mem_we.
- Stop sending after 3 bytes with TIMEOUT_CYCLES=100 → ERROR exactly 100 idle cycles after the last byte. A second load_req mid-frame is ignored.
- Assert rst during DATA_LO → all outputs at reset values next cycle, then RUN with cpu_rst=0.
